// File: rtl/uart_rx1_if.sv
// uart_rx1 link bundle: serial line in, byte plus
// status flags out toward the consumer.
interface uart_rx1_if;
  logic       RX;
  logic [7:0] Data_out;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  RX,
    output Data_out,
    output rx_valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport master (
    output RX,
    input  Data_out,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx1.sv
// uart_rx1: 11-bit frame receiver, MSB first, even parity.
// Optional RX synchronizer enabled by `define UART_RX_SYNC_EN.
module uart_rx1 #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx1_if.slave bus
);

  localparam int N  = CLKS_PER_BIT;
  localparam int H  = N / 2;
  localparam int CW = $clog2(N);

  localparam logic [CW-1:0] HM1 = CW'(H - 1);
  localparam logic [CW-1:0] NM1 = CW'(N - 1);

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic rx_s;
  logic rx_ok;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] flush_q;

  // ARM must not trust the reset value of the flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      flush_q <= 2'b00;
    end else begin
      sync_q  <= {sync_q[0], bus.RX};
      flush_q <= {flush_q[0], 1'b1};
    end
  end

  assign rx_s  = sync_q[1];
  assign rx_ok = flush_q[1];
`else
  assign rx_s  = bus.RX;
  assign rx_ok = 1'b1;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sreg_q, sreg_d;
  logic            par_q, par_d;
  logic [7:0]      data_q, data_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            vld_q, vld_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARM;
      cnt_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      par_q   <= par_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    par_d   = par_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    vld_d   = 1'b0;
    unique case (state_q)
      ARM: begin
        cnt_d = '0;
        if (rx_s && rx_ok)
          state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (!rx_s)
          state_d = START;
      end
      START: begin
        if (cnt_q == HM1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == NM1) begin
          cnt_d  = '0;
          sreg_d = {sreg_q[6:0], rx_s};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_d = PARITY;
        end
      end
      PARITY: begin
        if (cnt_q == NM1) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
      STOP: begin
        // leaving at mid-stop leaves H cycles for the next start
        if (cnt_q == NM1) begin
          cnt_d   = '0;
          data_d  = sreg_q;
          perr_d  = par_q ^ (^sreg_q);
          ferr_d  = ~rx_s;
          vld_d   = 1'b1;
          state_d = rx_s ? IDLE : ARM;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ARM;
      end
    endcase
  end

  assign bus.Data_out   = data_q;
  assign bus.rx_valid   = vld_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != ARM) &&
                          (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx1.sv
// tb_uart_rx1: scoreboard bench for uart_rx1 at N=8.
// Frames are queued when driven and matched on rx_valid.
module tb_uart_rx1;

  localparam int N = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk;
  logic rst;
  uart_rx1_if u_if();

  uart_rx1 #(.CLKS_PER_BIT(N)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   cyc      = 0;
  int   vcnt     = 0;
  exp_t sb[$];
  int   vt[$];

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    chk_cnt++;
    if (got === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.rx_valid === 1'b1) begin
      exp_t e;
      vcnt++;
      vt.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("data", {24'd0, u_if.Data_out},
            {24'd0, e.d});
        chk("parity_err", {31'd0, u_if.parity_err},
            {31'd0, e.pe});
        chk("frame_err", {31'd0, u_if.frame_err},
            {31'd0, e.fe});
      end
    end
  end

  task automatic send_frame(
    input logic [7:0] d,
    input logic       pflip,
    input logic       stop
  );
    logic [10:0] f;
    exp_t        e;
    f    = {1'b0, d, (^d) ^ pflip, stop};
    e.d  = d;
    e.pe = pflip;
    e.fe = ~stop;
    sb.push_back(e);
    for (int i = 10; i >= 0; i--) begin
      u_if.RX = f[i];
      repeat (N) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout want done");
    $display("%0d/%0d checks passed",
             pass_cnt, chk_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    rst     = 1'b0;
    u_if.RX = 1'b1;
    idle(3);
    chk("rst_data", {24'd0, u_if.Data_out}, 32'd0);
    chk("rst_valid", {31'd0, u_if.rx_valid}, 32'd0);
    chk("rst_perr", {31'd0, u_if.parity_err}, 32'd0);
    chk("rst_ferr", {31'd0, u_if.frame_err}, 32'd0);
    chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
    rst = 1'b1;
    idle(2 * N);

    send_frame(8'hA5, 1'b0, 1'b1);
    idle(4);
    chk("a5_drained", sb.size(), 32'd0);
    chk("a5_busy", {31'd0, u_if.busy}, 32'd0);

    send_frame(8'h3C, 1'b1, 1'b1);
    idle(3 * N);
    chk("perr_held", {31'd0, u_if.parity_err}, 32'd1);
    send_frame(8'h00, 1'b0, 1'b1);
    idle(4);
    chk("perr_clr", {31'd0, u_if.parity_err}, 32'd0);

    v0 = vcnt;
    send_frame(8'h81, 1'b0, 1'b0);
    idle(4 * N);
    chk("ferr_held", {31'd0, u_if.frame_err}, 32'd1);
    chk("arm_busy", {31'd0, u_if.busy}, 32'd0);
    u_if.RX = 1'b1;
    idle(3 * N);
    chk("ferr_one_valid", vcnt - v0, 32'd1);

    v0 = vcnt;
    u_if.RX = 1'b0;
    idle(1);
    chk("glitch_busy", {31'd0, u_if.busy}, 32'd1);
    idle(1);
    u_if.RX = 1'b1;
    idle(N);
    chk("glitch_drop", {31'd0, u_if.busy}, 32'd0);
    chk("glitch_novalid", vcnt - v0, 32'd0);
    idle(N);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(2 * N);

    v0 = vcnt;
    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'hFE, 1'b0, 1'b1);
    idle(4);
    chk("b2b_count", vcnt - v0, 32'd2);
    if (vt.size() >= 2)
      chk("b2b_gap", vt[vt.size()-1] - vt[vt.size()-2],
          32'd88);
    else
      chk("b2b_gap", 32'd0, 32'd88);
    idle(2 * N);

    v0 = vcnt;
    u_if.RX = 1'b0;
    idle(N);
    u_if.RX = 1'b1;
    idle(3 * N + N / 2);
    u_if.RX = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, u_if.busy}, 32'd0);
    chk("mid_rst_data", {24'd0, u_if.Data_out}, 32'd0);
    idle(3);
    rst = 1'b1;
    idle(3 * N);
    chk("low_arm_busy", {31'd0, u_if.busy}, 32'd0);
    u_if.RX = 1'b1;
    idle(2 * N);
    send_frame(8'hC3, 1'b0, 1'b1);
    idle(2 * N);
    chk("rst_one_valid", vcnt - v0, 32'd1);
    chk("c3_data", {24'd0, u_if.Data_out}, 32'h0C3);

    chk("sb_empty", sb.size(), 32'd0);
    chk("total_valid", vcnt, 32'd8);
    $display("%0d/%0d checks passed",
             pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx1.md
# uart_rx1

- Serial receiver for the team's UART link; decodes the 11-bit frame produced by our transmitter.
- Frame format: start 0, data bits 7..0 MSB first, even parity bit (XOR of the data), stop 1.
- Sits between the asynchronous RX pin and byte-wide consumer logic.
- Delivers each received byte with a one-cycle valid strobe and per-frame parity and framing error flags.

## Interface
- CLKS_PER_BIT, default 8: clk cycles per serial bit. Legal range 4..256, even values only.
- clk  input  1  system clock; every register updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- RX  input  1  serial line; idles high.
- Data_out  output  8  last received byte; reset 8'h00.
- rx_valid  output  1  one-cycle pulse when Data_out, parity_err and frame_err update; reset 0.
- parity_err  output  1  sampled parity bit != ^Data_out; held until the next rx_valid; reset 0.
- frame_err  output  1  sampled stop bit was 0; held until the next rx_valid; reset 0.
- busy  output  1  high in every state except ARM and IDLE; reset 0.

## Operation
- Let N = CLKS_PER_BIT and H = N/2.
- Counters:
  - baud_cnt is $clog2(N) bits wide, counts 0..N-1, and clears on every state change.
  - bit_cnt is 3 bits wide.
- rx_s is the line value the FSM sees (see Configuration).
- States and transitions:
  - ARM (reset state): wait for rx_s==1, then go to IDLE. A line held low in or after reset never starts a frame.
  - IDLE: on rx_s==0, go to START and set baud_cnt=0.
  - START: when baud_cnt==H-1 (the mid-start sample), check the line.
    - rx_s==1: glitch; return to IDLE with no outputs touched.
    - rx_s==0: go to DATA with bit_cnt=0.
  - DATA: every N cycles, at baud_cnt==N-1, shift sreg <= {sreg[6:0], rx_s}.
    - After bit_cnt==7, go to PARITY.
  - PARITY: at baud_cnt==N-1, latch par_bit=rx_s, then go to STOP.
  - STOP: at baud_cnt==N-1, complete the frame in that same edge:
    - Data_out <= sreg.
    - parity_err <= par_bit ^ (^sreg).
    - frame_err <= ~rx_s.
    - rx_valid <= 1.
    - Go to ARM when rx_s==0; otherwise go to IDLE.
- A byte is always delivered, even with an error; the flags qualify it.
- rx_valid deasserts on the following edge.

## Timing
- Edge E0 is the first edge at which IDLE sees rx_s==0.
- Sample edges, all measured from E0:
  - start at E0+H
  - data bit 7 at E0+H+N, bit 0 at E0+H+8N
  - parity at E0+H+9N
  - stop at E0+H+10N
- rx_valid is high for the single cycle after the stop-sample edge. With N=8 that is E0+84.
- Return to IDLE at mid-stop leaves H cycles of margin, so back-to-back frames with no idle gap are received without loss.
- Asynchronous reset mid-frame:
  - all state is cleared and the partial byte is discarded
  - outputs go immediately to their reset values
  - FSM returns to ARM
- RX glitches shorter than H cycles are rejected in START.

## Configuration
- UART_RX_SYNC_EN defined: RX passes through a two-flop synchronizer, both flops reset to 1, and rx_s is the second flop.
  - All sample edges shift 2 cycles later relative to the pin.
- UART_RX_SYNC_EN undefined: rx_s = RX directly, with no added latency. Use this only when RX is already synchronous to clk.

## Test plan
- Reset, hold RX=1, then send 8'hA5 with parity 0 and stop 1 at N=8 -> one rx_valid pulse, Data_out=8'hA5, parity_err=0, frame_err=0, busy low afterwards.
- Send 8'h3C with the parity bit forced to 1 -> Data_out=8'h3C, parity_err=1, frame_err=0. A following clean 8'h00 clears parity_err.
- Send 8'h81 with the stop bit forced to 0 -> Data_out=8'h81, frame_err=1. There is no further rx_valid until RX has returned high and a new start arrives.
- Pulse RX low for 2 cycles in IDLE -> no rx_valid, busy drops, and the next valid frame 8'h5A is received correctly.
- Send 8'h01 and 8'hFE back-to-back with no idle gap -> exactly two rx_valid pulses 11N cycles apart, carrying the correct bytes.
- Assert rst during data bit 4, hold RX low through and after reset, then release RX high and send 8'hC3 -> only one rx_valid, with Data_out=8'hC3.
